// File: rtl/ladybird_bus_arbiter_if.sv
// ladybird_config / ladybird_axi_interface: shared widths and the AXI4 port
// through which the bus arbiter reaches the system interconnect.
package ladybird_config;
    localparam int XLEN     = 32;
    localparam int N_REQ    = 2;
    localparam int AXI_ID_W = 4;
endpackage

interface ladybird_axi_interface;
    logic [ladybird_config::AXI_ID_W-1:0] awid;
    logic [ladybird_config::XLEN-1:0]     awaddr;
    logic [7:0]                           awlen;
    logic [2:0]                           awsize;
    logic [1:0]                           awburst;
    logic                                 awlock;
    logic [3:0]                           awcache;
    logic [2:0]                           awprot;
    logic                                 awvalid;
    logic                                 awready;
    logic [ladybird_config::AXI_ID_W-1:0] wid;
    logic [ladybird_config::XLEN-1:0]     wdata;
    logic [ladybird_config::XLEN/8-1:0]   wstrb;
    logic                                 wlast;
    logic                                 wvalid;
    logic                                 wready;
    logic [ladybird_config::AXI_ID_W-1:0] bid;
    logic [1:0]                           bresp;
    logic                                 bvalid;
    logic                                 bready;
    logic [ladybird_config::AXI_ID_W-1:0] arid;
    logic [ladybird_config::XLEN-1:0]     araddr;
    logic [7:0]                           arlen;
    logic [2:0]                           arsize;
    logic [1:0]                           arburst;
    logic                                 arlock;
    logic [3:0]                           arcache;
    logic [2:0]                           arprot;
    logic                                 arvalid;
    logic                                 arready;
    logic [ladybird_config::AXI_ID_W-1:0] rid;
    logic [ladybird_config::XLEN-1:0]     rdata;
    logic [1:0]                           rresp;
    logic                                 rlast;
    logic                                 rvalid;
    logic                                 rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/ladybird_bus_arbiter.sv
// ladybird_bus_arbiter: round-robin share of one AXI4 master port between
// instruction fetch (port 0) and load/store (port 1), one beat outstanding.
module ladybird_bus_arbiter
    import ladybird_config::*;
(
    input  logic                        clk,
    input  logic                        nrst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][XLEN-1:0]  req_addr,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ-1:0][XLEN-1:0]  req_wdata,
    input  logic [N_REQ-1:0][3:0]       req_wstrb,
    output logic [N_REQ-1:0]            rsp_valid,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [XLEN-1:0]             rsp_data,
    output logic                        rsp_err,
    ladybird_axi_interface.master       axi
);
    typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RSP} state_e;

    state_e            state_q, state_d;
    logic              last_q, g_q, we_q, aw_done_q, w_done_q, err_q;
    logic [XLEN-1:0]   addr_q, wdata_q, data_q;
    logic [3:0]        wstrb_q;
    logic              g, accept, aw_ok, w_ok;

    assign g      = &req_valid ? ~last_q : req_valid[1];
    // nrst gating keeps req_ready low while reset is held even though state is IDLE
    assign accept = nrst && state_q == IDLE && req_valid[g];
    assign req_ready = accept ? {g, ~g} : 2'b00;
    assign aw_ok  = aw_done_q | axi.awready;
    assign w_ok   = w_done_q | axi.wready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = req_we[g] ? AWW : AR;
            AR:      if (axi.arready) state_d = R;
            R:       if (axi.rvalid) state_d = RSP;
            AWW:     if (aw_ok && w_ok) state_d = B;
            B:       if (axi.bvalid) state_d = RSP;
            RSP:     if (rsp_ready[g_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            g_q       <= 1'b0;
            we_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            data_q    <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q    <= g;
                g_q       <= g;
                we_q      <= req_we[g];
                addr_q    <= req_addr[g];
                wdata_q   <= req_wdata[g];
                wstrb_q   <= req_wstrb[g];
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (state_q == AWW) begin
                aw_done_q <= aw_ok;
                w_done_q  <= w_ok;
            end
            if (state_q == R && axi.rvalid) begin
                data_q <= axi.rdata;
                err_q  <= (axi.rresp != 2'b00) || (axi.rid != AXI_ID_W'(g_q));
            end
            if (state_q == B && axi.bvalid) begin
                data_q <= '0;
                err_q  <= (axi.bresp != 2'b00) || (axi.bid != AXI_ID_W'(g_q));
            end
        end
    end

    assign axi.arvalid = state_q == AR;
    assign axi.arid    = AXI_ID_W'(g_q);
    assign axi.araddr  = addr_q & ~XLEN'(3);
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.rready  = state_q == R;

    assign axi.awvalid = state_q == AWW && !aw_done_q;
    assign axi.awid    = AXI_ID_W'(g_q);
    assign axi.awaddr  = addr_q & ~XLEN'(3);
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.wvalid  = state_q == AWW && !w_done_q && we_q;
    assign axi.wid     = AXI_ID_W'(g_q);
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.bready  = state_q == B;

    assign rsp_valid = state_q == RSP ? {g_q, ~g_q} : 2'b00;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// tb_ladybird_bus_arbiter: directed checks of arbitration, AXI sequencing,
// response holding, error reporting and asynchronous reset.
module tb_ladybird_bus_arbiter;
    logic              clk = 1'b0;
    logic              nrst;
    logic [1:0]        req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [1:0][31:0]  req_addr, req_wdata;
    logic [1:0][3:0]   req_wstrb;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    int                npass = 0, ntot = 0;

    logic [31:0] rdata_v;
    logic [1:0]  rresp_v, bresp_v;
    logic        rid_zero;
    int          ar_dly, aw_dly, w_dly, ar_cnt, aw_cnt, w_cnt;
    logic        r_pend, b_pend, aw_got, w_got;
    logic [3:0]  r_id, b_id;

    ladybird_axi_interface axi_if();

    ladybird_bus_arbiter dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .axi(axi_if.master)
    );

    always #5 clk = ~clk;

    // Behavioural single-beat AXI slave with programmable ready delays
    assign axi_if.arready = axi_if.arvalid && ar_cnt >= ar_dly;
    assign axi_if.awready = axi_if.awvalid && aw_cnt >= aw_dly;
    assign axi_if.wready  = axi_if.wvalid && w_cnt >= w_dly;
    assign axi_if.rvalid  = r_pend;
    assign axi_if.rid     = rid_zero ? 4'd0 : r_id;
    assign axi_if.rdata   = rdata_v;
    assign axi_if.rresp   = rresp_v;
    assign axi_if.rlast   = 1'b1;
    assign axi_if.bvalid  = b_pend;
    assign axi_if.bid     = b_id;
    assign axi_if.bresp   = bresp_v;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            r_id <= 4'd0; b_id <= 4'd0;
        end else begin
            ar_cnt <= (axi_if.arvalid && !axi_if.arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (axi_if.awvalid && !axi_if.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi_if.wvalid && !axi_if.wready) ? w_cnt + 1 : 0;
            if (axi_if.arvalid && axi_if.arready) begin
                r_pend <= 1'b1;
                r_id   <= axi_if.arid;
            end else if (r_pend && axi_if.rready) begin
                r_pend <= 1'b0;
            end
            if (axi_if.awvalid && axi_if.awready) b_id <= axi_if.awid;
            if ((aw_got || (axi_if.awvalid && axi_if.awready)) && (w_got || (axi_if.wvalid && axi_if.wready))) begin
                b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (axi_if.awvalid && axi_if.awready) aw_got <= 1'b1;
                if (axi_if.wvalid && axi_if.wready) w_got <= 1'b1;
                if (b_pend && axi_if.bready) b_pend <= 1'b0;
            end
        end
    end

    task automatic do_read(input logic p, input logic [31:0] a, output logic ok);
        logic acc;
        acc = 1'b0; ok = 1'b0;
        req_we = 2'b00; req_addr[p] = a; req_valid = p ? 2'b10 : 2'b01;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (rsp_valid[p]) begin ok = 1'b1; break; end
            if (req_ready[p]) acc = 1'b1;
            @(negedge clk);
            if (acc) req_valid = 2'b00;
        end
        req_valid = 2'b00;
    endtask

    task test_reset;
        nrst = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
        @(negedge clk); #1;
        ntot++; if ({req_ready, rsp_valid, rsp_err, rsp_data} !== 37'd0) $display("FAIL reset_outputs: got %h expected 0", {req_ready, rsp_valid, rsp_err, rsp_data}); else npass++;
        ntot++; if ({axi_if.arvalid, axi_if.awvalid, axi_if.wvalid, axi_if.rready, axi_if.bready} !== 5'b0) $display("FAIL reset_axi: got %b expected 00000", {axi_if.arvalid, axi_if.awvalid, axi_if.wvalid, axi_if.rready, axi_if.bready}); else npass++;
        req_valid = 2'b00; nrst = 1'b1;
        @(negedge clk);
    endtask

    task test_read_basic;
        rdata_v = 32'hDEAD_BEEF; rresp_v = 2'b00; rsp_ready = 2'b11;
        req_we = 2'b00; req_addr[1] = 32'h0000_1006; req_valid = 2'b10;
        #1;
        ntot++; if (req_ready !== 2'b10) $display("FAIL rd_accept: got %b expected 10", req_ready); else npass++;
        @(negedge clk); req_valid = 2'b00; #1;
        ntot++; if ({axi_if.arvalid, axi_if.arready, axi_if.araddr, axi_if.arid} !== {2'b11, 32'h0000_1004, 4'd1}) $display("FAIL rd_ar: got %h expected %h", {axi_if.arvalid, axi_if.arready, axi_if.araddr, axi_if.arid}, {2'b11, 32'h0000_1004, 4'd1}); else npass++;
        ntot++; if ({axi_if.arlen, axi_if.arsize, axi_if.arburst} !== {8'd0, 3'b010, 2'b01}) $display("FAIL rd_ar_fields: got %h expected %h", {axi_if.arlen, axi_if.arsize, axi_if.arburst}, {8'd0, 3'b010, 2'b01}); else npass++;
        @(negedge clk); #1;
        ntot++; if ({axi_if.rvalid, axi_if.rready, rsp_valid} !== 4'b1100) $display("FAIL rd_r: got %b expected 1100", {axi_if.rvalid, axi_if.rready, rsp_valid}); else npass++;
        @(negedge clk); #1;
        ntot++; if ({rsp_valid, rsp_data, rsp_err} !== {2'b10, 32'hDEAD_BEEF, 1'b0}) $display("FAIL rd_rsp: got %h expected %h", {rsp_valid, rsp_data, rsp_err}, {2'b10, 32'hDEAD_BEEF, 1'b0}); else npass++;
        @(negedge clk);
    endtask

    task test_alternate;
        int acc_n, last_c;
        logic expg, pend, pend_g;
        acc_n = 0; last_c = 0; expg = 1'b0; pend = 1'b0; pend_g = 1'b0;
        rdata_v = 32'hCAFE_F00D; rsp_ready = 2'b11; req_we = 2'b00;
        req_addr[0] = 32'h100; req_addr[1] = 32'h200; req_valid = 2'b11;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (pend) begin
                ntot++; if ({axi_if.arvalid, axi_if.arid} !== {1'b1, 3'b000, pend_g}) $display("FAIL alt_arid: got %h expected %h", {axi_if.arvalid, axi_if.arid}, {1'b1, 3'b000, pend_g}); else npass++;
                pend = 1'b0;
                if (acc_n == 4) break;
            end
            if (req_ready != 2'b00) begin
                ntot++; if (req_ready !== {expg, ~expg}) $display("FAIL alt_grant: got %b expected %b", req_ready, {expg, ~expg}); else npass++;
                if (acc_n > 0) begin
                    ntot++; if (c - last_c != 4) $display("FAIL alt_spacing: got %0d expected 4", c - last_c); else npass++;
                end
                last_c = c; pend = 1'b1; pend_g = expg; expg = ~expg; acc_n++;
            end
            @(negedge clk);
            if (acc_n == 4) req_valid = 2'b00;
        end
        req_valid = 2'b00;
        ntot++; if (acc_n != 4) $display("FAIL alt_count: got %0d expected 4", acc_n); else npass++;
        repeat (4) @(negedge clk);
    endtask

    task test_write;
        aw_dly = 3; w_dly = 0; bresp_v = 2'b00; rsp_ready = 2'b01;
        req_we = 2'b01; req_addr[0] = 32'h20; req_wdata[0] = 32'hA5A5_A5A5; req_wstrb[0] = 4'b0110;
        req_valid = 2'b01;
        #1;
        ntot++; if (req_ready !== 2'b01) $display("FAIL wr_accept: got %b expected 01", req_ready); else npass++;
        @(negedge clk); req_valid = 2'b00; #1;
        ntot++; if ({axi_if.awvalid, axi_if.awready, axi_if.wvalid, axi_if.wready} !== 4'b1011) $display("FAIL wr_c1: got %b expected 1011", {axi_if.awvalid, axi_if.awready, axi_if.wvalid, axi_if.wready}); else npass++;
        ntot++; if ({axi_if.awaddr, axi_if.wdata, axi_if.wstrb, axi_if.wlast, axi_if.wid} !== {32'h20, 32'hA5A5_A5A5, 4'b0110, 1'b1, 4'd0}) $display("FAIL wr_payload: got %h expected %h", {axi_if.awaddr, axi_if.wdata, axi_if.wstrb, axi_if.wlast, axi_if.wid}, {32'h20, 32'hA5A5_A5A5, 4'b0110, 1'b1, 4'd0}); else npass++;
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk); #1;
            ntot++; if ({axi_if.awvalid, axi_if.awready, axi_if.wvalid, axi_if.bready} !== 4'b1000) $display("FAIL wr_aw_wait: cycle %0d got %b expected 1000", i, {axi_if.awvalid, axi_if.awready, axi_if.wvalid, axi_if.bready}); else npass++;
        end
        @(negedge clk); #1;
        ntot++; if ({axi_if.awvalid, axi_if.awready, axi_if.wvalid, axi_if.bready} !== 4'b1100) $display("FAIL wr_aw_hs: got %b expected 1100", {axi_if.awvalid, axi_if.awready, axi_if.wvalid, axi_if.bready}); else npass++;
        @(negedge clk); #1;
        ntot++; if ({axi_if.awvalid, axi_if.wvalid, axi_if.bvalid, axi_if.bready} !== 4'b0011) $display("FAIL wr_b: got %b expected 0011", {axi_if.awvalid, axi_if.wvalid, axi_if.bvalid, axi_if.bready}); else npass++;
        @(negedge clk); #1;
        ntot++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b0, 32'h0}) $display("FAIL wr_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_data}, {2'b01, 1'b0, 32'h0}); else npass++;
        @(negedge clk);
        aw_dly = 0;
    endtask

    task test_read_errors;
        logic ok;
        rsp_ready = 2'b11; rdata_v = 32'h1111_1111; rresp_v = 2'b10;
        do_read(1'b0, 32'h40, ok);
        ntot++; if ({ok, rsp_err} !== 2'b11) $display("FAIL err_slverr: got %b expected 11", {ok, rsp_err}); else npass++;
        @(negedge clk); rresp_v = 2'b00; rid_zero = 1'b1;
        do_read(1'b1, 32'h44, ok);
        ntot++; if ({ok, rsp_err} !== 2'b11) $display("FAIL err_rid: got %b expected 11", {ok, rsp_err}); else npass++;
        @(negedge clk); rid_zero = 1'b0; rdata_v = 32'h2222_2222;
        do_read(1'b1, 32'h48, ok);
        ntot++; if ({ok, rsp_err, rsp_data} !== {2'b10, 32'h2222_2222}) $display("FAIL err_clean: got %h expected %h", {ok, rsp_err, rsp_data}, {2'b10, 32'h2222_2222}); else npass++;
        @(negedge clk);
    endtask

    task test_rsp_hold;
        logic ok;
        rsp_ready = 2'b10; rdata_v = 32'h1234_5678; rresp_v = 2'b00;
        do_read(1'b0, 32'h80, ok);
        ntot++; if (ok !== 1'b1) $display("FAIL hold_seen: got %b expected 1", ok); else npass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); req_valid = 2'b11; #1;
            ntot++; if ({rsp_valid, rsp_data, rsp_err, req_ready} !== {2'b01, 32'h1234_5678, 1'b0, 2'b00}) $display("FAIL hold_rsp: cycle %0d got %h expected %h", i, {rsp_valid, rsp_data, rsp_err, req_ready}, {2'b01, 32'h1234_5678, 1'b0, 2'b00}); else npass++;
            ntot++; if ({axi_if.arvalid, axi_if.awvalid, axi_if.wvalid} !== 3'b000) $display("FAIL hold_axi: cycle %0d got %b expected 000", i, {axi_if.arvalid, axi_if.awvalid, axi_if.wvalid}); else npass++;
        end
        @(negedge clk); req_valid = 2'b00; rsp_ready = 2'b01;
        @(negedge clk); #1;
        ntot++; if (rsp_valid !== 2'b00) $display("FAIL hold_release: got %b expected 00", rsp_valid); else npass++;
        @(negedge clk);
    endtask

    task test_async_reset;
        rdata_v = 32'h0000_0055; rsp_ready = 2'b01;
        req_we = 2'b00; req_addr[0] = 32'h90; req_valid = 2'b01;
        #1;
        ntot++; if (req_ready !== 2'b01) $display("FAIL ar_accept: got %b expected 01", req_ready); else npass++;
        @(negedge clk); req_valid = 2'b00;
        @(negedge clk); #1;
        ntot++; if ({axi_if.rvalid, axi_if.rready} !== 2'b11) $display("FAIL ar_in_r: got %b expected 11", {axi_if.rvalid, axi_if.rready}); else npass++;
        nrst = 1'b0; req_valid = 2'b11; #1;
        ntot++; if ({req_ready, rsp_valid, rsp_err, rsp_data} !== 37'd0) $display("FAIL ar_outputs: got %h expected 0", {req_ready, rsp_valid, rsp_err, rsp_data}); else npass++;
        ntot++; if ({axi_if.arvalid, axi_if.awvalid, axi_if.wvalid, axi_if.rready, axi_if.bready} !== 5'b0) $display("FAIL ar_axi: got %b expected 00000", {axi_if.arvalid, axi_if.awvalid, axi_if.wvalid, axi_if.rready, axi_if.bready}); else npass++;
        @(negedge clk); nrst = 1'b1; #1;
        ntot++; if (req_ready !== 2'b01) $display("FAIL ar_first_tie: got %b expected 01", req_ready); else npass++;
        @(negedge clk); req_valid = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        req_valid = 2'b00; req_we = 2'b00; rsp_ready = 2'b00;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rdata_v = 32'h0; rresp_v = 2'b00; bresp_v = 2'b00; rid_zero = 1'b0;
        ar_dly = 0; aw_dly = 0; w_dly = 0;
        test_reset;
        test_read_basic;
        test_alternate;
        test_write;
        test_read_errors;
        test_rsp_hold;
        test_async_reset;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
